// File: rtl/alarm_pkg.sv
// Shared encodings and 12-hour BCD increment rules for the alarm clock.
// Used by both the time counter and the alarm controller.
package alarm_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'b00,
        MODE_SET_TIME  = 2'b01,
        MODE_SET_ALARM = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        R_IDLE   = 2'b00,
        R_RING   = 2'b01,
        R_SNOOZE = 2'b10
    } ring_e;

    // 12 -> 01, 09 -> 10, otherwise +1
    function automatic logic [7:0] bcd12_hour_inc(
        input logic [3:0] hourten,
        input logic [3:0] hour
    );
        logic [7:0] r;
        if (hourten == 4'd1 && hour == 4'd2) begin
            r = {4'd0, 4'd1};
        end else if (hour == 4'd9) begin
            r = {hourten + 4'd1, 4'd0};
        end else begin
            r = {hourten, hour + 4'd1};
        end
        return r;
    endfunction

    // 59 -> 00 with no carry out to the hour
    function automatic logic [7:0] bcd_min_inc(
        input logic [3:0] minten,
        input logic [3:0] min
    );
        logic [7:0] r;
        if (min == 4'd9) begin
            r = (minten == 4'd5) ? 8'h00 : {minten + 4'd1, 4'd0};
        end else begin
            r = {minten, min + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_ring_fsm.sv
// Ring/snooze sequencer with saturating minute-tick counters.
// Disabling the alarm or entering a set mode returns it to idle.
module alarm_ring_fsm
    import alarm_pkg::*;
#(
    parameter int SNOOZE_TICKS = 9,
    parameter int RING_TIMEOUT = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic trig,
    input  logic btn_snooze,
    input  logic alarm_en,
    input  logic force_idle,
    output logic ring
);

    localparam logic [7:0] RT = 8'(RING_TIMEOUT);
    localparam logic [7:0] ST = 8'(SNOOZE_TICKS);

    ring_e      state_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_inc;
    logic       ring_q;

    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst || !alarm_en || force_idle) begin
            state_q <= R_IDLE;
            cnt_q   <= 8'd0;
            ring_q  <= 1'b0;
        end else begin
            unique case (state_q)
                R_IDLE: begin
                    if (trig) begin
                        state_q <= R_RING;
                        cnt_q   <= 8'd0;
                        ring_q  <= 1'b1;
                    end
                end
                R_RING: begin
                    // snooze outranks a timeout tick in the same cycle
                    if (btn_snooze) begin
                        state_q <= R_SNOOZE;
                        cnt_q   <= 8'd0;
                        ring_q  <= 1'b0;
                    end else if (tick) begin
                        if (cnt_inc >= RT) begin
                            state_q <= R_IDLE;
                            cnt_q   <= 8'd0;
                            ring_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                R_SNOOZE: begin
                    if (tick) begin
                        if (cnt_inc >= ST) begin
                            state_q <= R_RING;
                            cnt_q   <= 8'd0;
                            ring_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                default: begin
                    state_q <= R_IDLE;
                    cnt_q   <= 8'd0;
                    ring_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ring = ring_q;

endmodule

// File: rtl/alarm_controller.sv
// Mode sequencer, set pulses, alarm register and match detect.
// All outputs are registered one cycle after their input pulse.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int SNOOZE_TICKS = 9,
    parameter int RING_TIMEOUT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_hour,
    input  logic       btn_min,
    input  logic       btn_snooze,
    input  logic       alarm_en,
    input  logic [3:0] t_min,
    input  logic [3:0] t_minten,
    input  logic [3:0] t_hour,
    input  logic [3:0] t_hourten,
    output logic       cnt_en,
    output logic       set_hour,
    output logic       set_min,
    output logic [3:0] a_min,
    output logic [3:0] a_minten,
    output logic [3:0] a_hour,
    output logic [3:0] a_hourten,
    output logic       disp_alarm,
    output logic [1:0] mode,
    output logic       ring
);

    mode_e       mode_q, mode_d;
    logic [15:0] alarm_q, alarm_d;
    logic        cnt_en_q, set_hour_q, set_min_q;
    logic        disp_q, eq_q;
    logic        eq, trig, force_idle;
    logic        set_time, set_alarm;

    assign set_time  = (mode_q == MODE_SET_TIME) && !btn_mode;
    assign set_alarm = (mode_q == MODE_SET_ALARM) && !btn_mode;

    always_comb begin
        mode_d = mode_q;
        if (btn_mode) begin
            unique case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_TIME;
                MODE_SET_TIME: mode_d = MODE_SET_ALARM;
                default:       mode_d = MODE_RUN;
            endcase
        end
    end

    always_comb begin
        alarm_d = alarm_q;
        if (set_alarm && btn_hour)
            alarm_d[15:8] = bcd12_hour_inc(alarm_q[15:12], alarm_q[11:8]);
        if (set_alarm && btn_min)
            alarm_d[7:0] = bcd_min_inc(alarm_q[7:4], alarm_q[3:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_RUN;
            alarm_q    <= 16'h1200;
            cnt_en_q   <= 1'b0;
            set_hour_q <= 1'b0;
            set_min_q  <= 1'b0;
            disp_q     <= 1'b0;
            eq_q       <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            alarm_q    <= alarm_d;
            cnt_en_q   <= tick && (mode_q == MODE_RUN);
            set_hour_q <= set_time && btn_hour;
            set_min_q  <= set_time && btn_min;
            disp_q     <= (mode_d == MODE_SET_ALARM);
            eq_q       <= eq;
        end
    end

    assign eq = ({t_hourten, t_hour, t_minten, t_min} == alarm_q);
    assign trig = eq && !eq_q && alarm_en && (mode_q == MODE_RUN);
    // leaving RUN for either set mode silences the alarm
    assign force_idle = btn_mode && (mode_q != MODE_SET_ALARM);

    alarm_ring_fsm #(
        .SNOOZE_TICKS (SNOOZE_TICKS),
        .RING_TIMEOUT (RING_TIMEOUT)
    ) u_ring (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .trig       (trig),
        .btn_snooze (btn_snooze),
        .alarm_en   (alarm_en),
        .force_idle (force_idle),
        .ring       (ring)
    );

    assign mode       = mode_q;
    assign cnt_en     = cnt_en_q;
    assign set_hour   = set_hour_q;
    assign set_min    = set_min_q;
    assign disp_alarm = disp_q;
    assign a_hourten  = alarm_q[15:12];
    assign a_hour     = alarm_q[11:8];
    assign a_minten   = alarm_q[7:4];
    assign a_min      = alarm_q[3:0];

endmodule
